seq_divider: RTL and testbench

Sequential unsigned restoring divider, the inverse companion to the team's array multiplier. It computes one quotient bit per clock using a WIDTH+1-bit trial subtractor. The subtractor is built as an add of the inverted divisor with carry-in = 1, the same ripple full-adder chain style the multiplier uses. A start/busy/done handshake lets a controller or testbench launch a division and collect quotient and remainder.

---
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock using a
// WIDTH+1-bit trial subtractor built as a ripple full-adder chain
// (trial + ~divisor + 1).
//
// Handshake: start is accepted only when the FSM is IDLE and busy is low.
// busy and done are registered, so each one trails the FSM state by one edge.
// done pulses for one cycle, and quotient/remainder/div_by_zero are valid from
// that cycle on. They hold their values until the next accepted start clears them.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_shift;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] rem;       // working remainder, always < divisor
  logic [WIDTH-1:0] dvsr;      // latched divisor
  logic             accept;

  // Trial subtractor: trial - {0, dvsr} as trial + ~{0, dvsr} + 1.
  // A carry out of the top bit means there was no borrow.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH-1:0] diff;
  logic [WIDTH+1:0] carry;
  logic             no_borrow;

  assign accept   = (state == IDLE) && start && !busy;
  assign trial    = {rem, q_shift[WIDTH-1]};
  assign sub_b    = ~{1'b0, dvsr};
  assign carry[0] = 1'b1;

  // Ripple full-adder chain. The top sum bit is never stored because the
  // remainder fits in WIDTH bits, so only its carry is generated.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign carry[i+1] = (trial[i] & sub_b[i]) | (carry[i] & (trial[i] ^ sub_b[i]));
    if (i < WIDTH) begin : g_sum
      assign diff[i] = trial[i] ^ sub_b[i] ^ carry[i];
    end
  end

  assign no_borrow = carry[WIDTH+1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (divisor != '0) ? RUN : DONE;
      RUN:  if (count == CW'(1)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, restoring iteration, and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      q_shift     <= '0;
      rem         <= '0;
      dvsr        <= '0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            q_shift     <= dividend;
            dvsr        <= divisor;
            rem         <= '0;
            count       <= (divisor != '0) ? COUNT_INIT : '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          rem     <= no_borrow ? diff : trial[WIDTH-1:0];
          q_shift <= {q_shift[WIDTH-2:0], no_borrow};
          count   <= count - CW'(1);
        end
        DONE: begin
          if (dvsr == '0) begin
            // q_shift still holds the untouched dividend here.
            quotient    <= '1;
            remainder   <= q_shift;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_shift;
            remainder   <= rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider (WIDTH=8): directed cases, then a random
// back-to-back sweep. Results are checked against plain arithmetic (/ and %).
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  // Expected results queue, packed as {div_by_zero, quotient, remainder}.
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: plain division. A zero divisor gives all ones and the dividend.
  function automatic logic [2*W:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [W-1:0] q;
    logic [W-1:0] r;
    if (d == 0) return {1'b1, {W{1'b1}}, n};
    q = W'(int'(n) / int'(d));
    r = W'(int'(n) % int'(d));
    return {1'b0, q, r};
  endfunction

  // Launch one division from a negedge in an idle cycle.
  // inject_at >= 0 pulses a stray 50/5 start at the negedge after that many
  // post-acceptance edges, and leaves those operands on the inputs.
  // Returns at the negedge of the cycle following done.
  task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d, input int inject_at,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                         output int lat, output int bcnt, output bit ok);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; ok = 0; q = '0; r = '0; z = 1'b0;
    @(negedge clk);
    if (busy) bcnt++;
    for (int i = 1; i <= 40 && !ok; i++) begin
      if (i - 1 == inject_at) begin
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
      end
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        ok = 1; lat = i; q = quotient; r = remainder; z = div_by_zero;
      end
    end
    if (ok) @(negedge clk);
  endtask

  // Run one division and score it against the expected queue.
  task automatic do_case(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                         input int inject_at, input bit full);
    logic [W-1:0] q, r;
    logic         z;
    int           lat, bcnt;
    bit           ok;
    logic [2*W:0] e;
    exp_q.push_back(model(n, d));
    run_div(n, d, inject_at, q, r, z, lat, bcnt, ok);
    e = exp_q.pop_front();
    check({tag, " completed"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, " quotient"}, 32'(q), 32'(e[2*W-1:W]));
      check({tag, " remainder"}, 32'(r), 32'(e[W-1:0]));
      check({tag, " div_by_zero"}, 32'(z), 32'(e[2*W]));
      if (full) begin
        check({tag, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'(W + 1));
        check({tag, " busy cycles"}, 32'(bcnt), (d == 0) ? 32'd1 : 32'(W + 1));
        check({tag, " done drops"}, 32'(done), 32'd0);
        check({tag, " busy drops"}, 32'(busy), 32'd0);
        check({tag, " quotient held"}, 32'(quotient), 32'(e[2*W-1:W]));
      end
    end
  endtask

  // Directed sequence, then a random sweep.
  initial begin
    logic [W-1:0] n, d, q, r;
    logic         z;
    int           lat, bcnt;
    bit           ok;

    // Reset.
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic cases and boundaries.
    do_case("100/7", 8'd100, 8'd7, -1, 1);
    do_case("255/1", 8'd255, 8'd1, -1, 1);
    do_case("5/9", 8'd5, 8'd9, -1, 1);
    do_case("255/255", 8'd255, 8'd255, -1, 1);
    do_case("200/0", 8'd200, 8'd0, -1, 1);
    do_case("after div0 100/7", 8'd100, 8'd7, -1, 1);

    // A start pulsed during RUN is ignored, and timing is unchanged.
    do_case("ignored start", 8'd100, 8'd7, 2, 1);

    // Reset in the fourth RUN cycle aborts the division.
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_case("99/10 after abort", 8'd99, 8'd10, -1, 1);

    // Random back-to-back sweep, each start in the idle cycle after done.
    for (int k = 0; k < 500; k++) begin
      n = W'($urandom_range(0, 255));
      d = W'($urandom_range(1, 255));
      run_div(n, d, -1, q, r, z, lat, bcnt, ok);
      check("sweep completed", 32'(ok), 32'd1);
      if (ok) begin
        check("sweep identity", 32'(int'(q) * int'(d) + int'(r)), 32'(n));
        check("sweep remainder bound", 32'(r < d), 32'd1);
        check("sweep div_by_zero", 32'(z), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
